// File: rtl/lsu_sram_bridge.sv
// Bridges core LSU byte/half/word requests onto single-cycle 32b SRAM controller commands,
// handling lane alignment, load extension, and misaligned/range/timeout error completion.
module lsu_sram_bridge #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_lsu_valid,
  input  logic        i_lsu_we,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_lsu_wdata,
  input  logic [1:0]  i_lsu_size,
  input  logic        i_lsu_unsigned,
  output logic [31:0] o_lsu_rdata,
  output logic        o_lsu_done,
  output logic        o_lsu_err,
  output logic        o_lsu_busy,
  output logic [17:0] o_sram_addr,
  output logic [31:0] o_sram_wdata,
  output logic [3:0]  o_sram_bmask,
  output logic        o_sram_wren,
  output logic        o_sram_rden,
  input  logic [31:0] i_sram_rdata,
  input  logic        i_sram_ack
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e             state_q, state_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [18:0]        addr_q, addr_d;
  logic               we_q, we_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         bmask_q, bmask_d;
  logic               issue;

  function automatic logic req_err(input logic [31:0] a, input logic [1:0] s);
    req_err = (s == 2'b11) || ((s == 2'b01) && a[0]) || ((s == 2'b10) && (a[1:0] != 2'b00)) ||
              (a[31:19] != BASE_ADDR[31:19]);
  endfunction

  function automatic logic [31:0] store_data(input logic [31:0] wd, input logic [1:0] s);
    case (s)
      2'b00:   store_data = {4{wd[7:0]}};
      2'b01:   store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  function automatic logic [3:0] store_mask(input logic [1:0] o, input logic [1:0] s);
    case (s)
      2'b00:   store_mask = 4'b0001 << o;
      2'b01:   store_mask = o[1] ? 4'b1100 : 4'b0011;
      default: store_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] r, input logic [1:0] o,
                                               input logic [1:0] s, input logic u);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    b   = r[{o, 3'b000} +: 8];
    h   = r[{o[1], 4'b0000} +: 16];
    ext = $signed(r);
    case (s)
      2'b00:   if (u) ext = $signed({24'h0, b}); else ext = b;
      2'b01:   if (u) ext = $signed({16'h0, h}); else ext = h;
      default: ext = $signed(r);
    endcase
    load_extract = ext;
  endfunction

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = '0;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    bmask_d = bmask_q;
    case (state_q)
      S_IDLE: begin
        if (i_lsu_valid) begin
          addr_d  = i_lsu_addr[18:0];
          we_d    = i_lsu_we;
          size_d  = i_lsu_size;
          uns_d   = i_lsu_unsigned;
          wdata_d = store_data(i_lsu_wdata, i_lsu_size);
          bmask_d = i_lsu_we ? store_mask(i_lsu_addr[1:0], i_lsu_size) : 4'b1111;
          err_d   = req_err(i_lsu_addr, i_lsu_size);
          state_d = req_err(i_lsu_addr, i_lsu_size) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // Ack wins over a timeout landing in the same cycle.
        if (i_sram_ack) begin
          if (!we_q) rdata_d = load_extract(i_sram_rdata, addr_q[1:0], size_q, uns_q);
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_d == CNT_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // control state: reset applies here only
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // request capture: data-only, outputs are gated by state so no reset needed
  always_ff @(posedge i_clk) begin
    addr_q  <= addr_d;
    we_q    <= we_d;
    size_q  <= size_d;
    uns_q   <= uns_d;
    wdata_q <= wdata_d;
    bmask_q <= bmask_d;
  end

  assign issue        = (state_q == S_ISSUE);
  assign o_lsu_busy   = (state_q != S_IDLE);
  assign o_lsu_done   = (state_q == S_DONE);
  assign o_lsu_err    = o_lsu_done & err_q;
  assign o_lsu_rdata  = rdata_q;
  assign o_sram_wren  = issue & we_q;
  assign o_sram_rden  = issue & ~we_q;
  assign o_sram_addr  = issue ? {addr_q[18:2], 1'b0} : 18'h0;
  assign o_sram_wdata = (issue & we_q) ? wdata_q : 32'h0;
  assign o_sram_bmask = issue ? bmask_q : 4'h0;

endmodule
